// File: rtl/riscv_debug_ring_router_mc_if.sv
// Handshake bundle for the multi-channel debug ring router: per-channel ring ports plus local inject/eject.
// The router takes the slave view; whatever drives and drains it takes the master view.
interface riscv_debug_ring_router_mc_if #(
    parameter int XLEN     = 64,
    parameter int CHANNELS = 2
);
    // valid/ready: a flit moves when valid && ready at a rising edge; the sender keeps valid,
    // data and last stable until then, and valid never waits on ready.
    logic [CHANNELS*XLEN-1:0] ring_in_data;
    logic [CHANNELS-1:0]      ring_in_last;
    logic [CHANNELS-1:0]      ring_in_valid;
    logic [CHANNELS-1:0]      ring_in_ready;
    logic [CHANNELS*XLEN-1:0] ring_out_data;
    logic [CHANNELS-1:0]      ring_out_last;
    logic [CHANNELS-1:0]      ring_out_valid;
    logic [CHANNELS-1:0]      ring_out_ready;
    logic [XLEN-1:0]          local_in_data;
    logic                     local_in_last;
    logic                     local_in_valid;
    logic                     local_in_ready;
    logic [XLEN-1:0]          local_out_data;
    logic                     local_out_last;
    logic                     local_out_valid;
    logic                     local_out_ready;

    modport slave (
        input  ring_in_data, ring_in_last, ring_in_valid,
        output ring_in_ready,
        output ring_out_data, ring_out_last, ring_out_valid,
        input  ring_out_ready,
        input  local_in_data, local_in_last, local_in_valid,
        output local_in_ready,
        output local_out_data, local_out_last, local_out_valid,
        input  local_out_ready
    );

    modport master (
        output ring_in_data, ring_in_last, ring_in_valid,
        input  ring_in_ready,
        input  ring_out_data, ring_out_last, ring_out_valid,
        output ring_out_ready,
        output local_in_data, local_in_last, local_in_valid,
        input  local_in_ready,
        input  local_out_data, local_out_last, local_out_valid,
        output local_out_ready
    );
endinterface

// File: rtl/riscv_debug_ring_router_mc.sv
// Multi-channel debug ring router: ejects packets addressed to this node, forwards the rest on
// their own channel, and injects local packets on INJECT_CH with packet-atomic round-robin arbitration.
module riscv_debug_ring_router_mc #(
    parameter int XLEN      = 64,
    parameter int CHANNELS  = 2,
    parameter int ID_W      = 16,
    parameter int INJECT_CH = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XLEN-1:0]             id,
    riscv_debug_ring_router_mc_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]      in_mid_q, in_mid_d;
    logic [CHANNELS-1:0]      in_local_q, in_local_d;
    logic [CHANNELS-1:0]      ro_valid_q, ro_valid_d;
    logic [CHANNELS-1:0]      ro_last_q, ro_last_d;
    logic [CHANNELS*XLEN-1:0] ro_data_q, ro_data_d;
    logic                     lo_valid_q, lo_valid_d;
    logic                     lo_last_q, lo_last_d;
    logic [XLEN-1:0]          lo_data_q, lo_data_d;
    logic                     inj_lock_q, inj_lock_d;
    logic                     inj_own_local_q, inj_own_local_d;
    logic                     inj_pri_local_q, inj_pri_local_d;
    logic                     lo_lock_q, lo_lock_d;
    logic [CW-1:0]            lo_own_q, lo_own_d;
    logic [CW-1:0]            lo_rr_q, lo_rr_d;

    logic [CHANNELS-1:0] route_local, req_loc, ro_can_load, in_ready, in_xfer;
    logic                inj_req_ring, lo_can_load, inj_gnt_local, local_ready, local_xfer;
    logic [CW-1:0]       lo_sel;
    int                  lo_best, lo_dist;
    logic                id_unused;

    // Only the low ID_W bits of id take part in routing.
    assign id_unused = ^id;

    always_comb begin
        route_local = '0;
        in_ready    = '0;
        lo_dist     = 0;
        lo_best     = CHANNELS;

        // Headers decide the route from their own destination; later flits reuse the latched route.
        for (int c = 0; c < CHANNELS; c++) begin
            route_local[c] = in_mid_q[c] ? in_local_q[c]
                           : (bus.ring_in_data[c*XLEN +: ID_W] == id[ID_W-1:0]);
        end
        req_loc      = bus.ring_in_valid & route_local;
        inj_req_ring = bus.ring_in_valid[INJECT_CH] & ~route_local[INJECT_CH];
        ro_can_load  = ~ro_valid_q | bus.ring_out_ready;
        lo_can_load  = ~lo_valid_q | bus.local_out_ready;

        if (inj_lock_q)
            inj_gnt_local = inj_own_local_q;
        else if (inj_req_ring && bus.local_in_valid)
            inj_gnt_local = inj_pri_local_q;
        else
            inj_gnt_local = bus.local_in_valid;

        // Local-out winner: the requesting channel closest at or after the rr pointer.
        lo_sel = lo_lock_q ? lo_own_q : lo_rr_q;
        if (!lo_lock_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (req_loc[c]) begin
                    lo_dist = (c + CHANNELS - int'(lo_rr_q)) % CHANNELS;
                    if (lo_dist < lo_best) begin
                        lo_best = lo_dist;
                        lo_sel  = CW'(c);
                    end
                end
            end
        end

        for (int c = 0; c < CHANNELS; c++) begin
            if (route_local[c])
                in_ready[c] = !rst && (lo_sel == CW'(c)) && lo_can_load;
            else if (c == INJECT_CH)
                in_ready[c] = !rst && !inj_gnt_local && ro_can_load[c];
            else
                in_ready[c] = !rst && ro_can_load[c];
        end
        local_ready = !rst && inj_gnt_local && ro_can_load[INJECT_CH];
        in_xfer     = bus.ring_in_valid & in_ready;
        local_xfer  = bus.local_in_valid && local_ready;

        in_mid_d   = in_mid_q;
        in_local_d = in_local_q;
        ro_valid_d = ro_valid_q;
        ro_last_d  = ro_last_q;
        ro_data_d  = ro_data_q;
        lo_valid_d = lo_valid_q;
        lo_last_d  = lo_last_q;
        lo_data_d  = lo_data_q;
        lo_lock_d  = lo_lock_q;
        lo_own_d   = lo_own_q;
        lo_rr_d    = lo_rr_q;

        for (int c = 0; c < CHANNELS; c++) begin
            if (in_xfer[c]) begin
                in_mid_d[c]   = !bus.ring_in_last[c];
                in_local_d[c] = route_local[c];
            end
            if (ro_can_load[c]) begin
                ro_valid_d[c] = 1'b0;
                if (c == INJECT_CH && local_xfer) begin
                    ro_valid_d[c]              = 1'b1;
                    ro_last_d[c]               = bus.local_in_last;
                    ro_data_d[c*XLEN +: XLEN]  = bus.local_in_data;
                end else if (in_xfer[c] && !route_local[c]) begin
                    ro_valid_d[c]              = 1'b1;
                    ro_last_d[c]               = bus.ring_in_last[c];
                    ro_data_d[c*XLEN +: XLEN]  = bus.ring_in_data[c*XLEN +: XLEN];
                end
            end
        end

        if (lo_can_load) lo_valid_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_xfer[c] && route_local[c]) begin
                lo_valid_d = 1'b1;
                lo_last_d  = bus.ring_in_last[c];
                lo_data_d  = bus.ring_in_data[c*XLEN +: XLEN];
                lo_lock_d  = !bus.ring_in_last[c];
                lo_own_d   = CW'(c);
                if (bus.ring_in_last[c]) lo_rr_d = CW'((c + 1) % CHANNELS);
            end
        end

        // Completing a packet hands priority to the other requester of the inject output.
        inj_lock_d      = inj_lock_q;
        inj_own_local_d = inj_own_local_q;
        inj_pri_local_d = inj_pri_local_q;
        if (local_xfer) begin
            inj_lock_d      = !bus.local_in_last;
            inj_own_local_d = 1'b1;
            if (bus.local_in_last) inj_pri_local_d = 1'b0;
        end else if (in_xfer[INJECT_CH] && !route_local[INJECT_CH]) begin
            inj_lock_d      = !bus.ring_in_last[INJECT_CH];
            inj_own_local_d = 1'b0;
            if (bus.ring_in_last[INJECT_CH]) inj_pri_local_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_mid_q        <= '0;
            in_local_q      <= '0;
            ro_valid_q      <= '0;
            ro_last_q       <= '0;
            ro_data_q       <= '0;
            lo_valid_q      <= 1'b0;
            lo_last_q       <= 1'b0;
            lo_data_q       <= '0;
            inj_lock_q      <= 1'b0;
            inj_own_local_q <= 1'b0;
            inj_pri_local_q <= 1'b0;
            lo_lock_q       <= 1'b0;
            lo_own_q        <= '0;
            lo_rr_q         <= '0;
        end else begin
            in_mid_q        <= in_mid_d;
            in_local_q      <= in_local_d;
            ro_valid_q      <= ro_valid_d;
            ro_last_q       <= ro_last_d;
            ro_data_q       <= ro_data_d;
            lo_valid_q      <= lo_valid_d;
            lo_last_q       <= lo_last_d;
            lo_data_q       <= lo_data_d;
            inj_lock_q      <= inj_lock_d;
            inj_own_local_q <= inj_own_local_d;
            inj_pri_local_q <= inj_pri_local_d;
            lo_lock_q       <= lo_lock_d;
            lo_own_q        <= lo_own_d;
            lo_rr_q         <= lo_rr_d;
        end
    end

    assign bus.ring_in_ready   = in_ready;
    assign bus.local_in_ready  = local_ready;
    assign bus.ring_out_valid  = ro_valid_q;
    assign bus.ring_out_last   = ro_last_q;
    assign bus.ring_out_data   = ro_data_q;
    assign bus.local_out_valid = lo_valid_q;
    assign bus.local_out_last  = lo_last_q;
    assign bus.local_out_data  = lo_data_q;
endmodule

// File: tb/tb_riscv_debug_ring_router_mc.sv
// Randomized bench for the debug ring router: per-source packet queues feed a per-(output,source)
// scoreboard that checks routing, order, packet atomicity, latency and round-robin alternation.
module tb_riscv_debug_ring_router_mc;
    localparam int XLEN      = 64;
    localparam int CHANNELS  = 2;
    localparam int ID_W      = 16;
    localparam int INJECT_CH = 0;
    localparam int NS        = CHANNELS + 1;  // sources: ring_in[0..], then local_in
    localparam int NO        = CHANNELS + 1;  // outputs: ring_out[0..], then local_out
    localparam logic [15:0] NODE_ID = 16'h0005;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] id;

    riscv_debug_ring_router_mc_if #(.XLEN(XLEN), .CHANNELS(CHANNELS)) bus ();

    riscv_debug_ring_router_mc #(
        .XLEN(XLEN), .CHANNELS(CHANNELS), .ID_W(ID_W), .INJECT_CH(INJECT_CH)
    ) dut (
        .clk(clk), .rst(rst), .id(id), .bus(bus)
    );

    always #5 clk = ~clk;

    // Scoreboard and stimulus state; flits are {last, data}.
    logic [XLEN:0] src_q [NS][$];
    logic [XLEN:0] exp_q [NO*NS][$];
    int            hdr_log [NO][$];
    bit            cur_v [NS];
    int            gap_pct [NS];
    int            rdy_pct [NO];
    int            lock_src [NO];
    int            rx_cnt [NO], first_rx [NO], last_rx [NO];
    int            tx_cnt [NS], first_tx [NS], stall_cnt [NS];
    int            cyc = 0, seq = 0;
    bit            rst_prev = 1'b0;
    int            n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            src_q[s].delete();
            cur_v[s] = 1'b0;
        end
        for (int k = 0; k < NO*NS; k++) exp_q[k].delete();
        for (int o = 0; o < NO; o++) lock_src[o] = -1;
    endtask

    task automatic clear_stats();
        for (int o = 0; o < NO; o++) begin
            rx_cnt[o] = 0; first_rx[o] = -1; last_rx[o] = -1;
            hdr_log[o].delete();
        end
        for (int s = 0; s < NS; s++) begin
            tx_cnt[s] = 0; first_tx[s] = -1; stall_cnt[s] = 0;
        end
    endtask

    function automatic bit all_empty();
        for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) return 1'b0;
        for (int k = 0; k < NO*NS; k++) if (exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Ring sources go local when the header matches the node id, else stay on their channel;
    // the local source always lands on ring_out[INJECT_CH].
    task automatic gen_packet(input int s, input int nflits, input bit to_local);
        logic [15:0]   dest;
        logic [XLEN:0] f;
        int            o;
        dest = to_local ? NODE_ID : (NODE_ID ^ 16'($urandom_range(1, 65535)));
        if (s == CHANNELS)  o = INJECT_CH;
        else if (to_local)  o = CHANNELS;
        else                o = s;
        for (int i = 0; i < nflits; i++) begin
            f = {(i == nflits - 1), 8'(s), 24'(seq), 16'($urandom),
                 (i == 0) ? dest : 16'($urandom)};
            seq++;
            src_q[s].push_back(f);
            exp_q[o*NS + s].push_back(f);
        end
    endtask

    task automatic monitor(input int o, input logic [XLEN:0] f);
        int s;
        s = int'(f[XLEN-1 -: 8]);
        rx_cnt[o]++;
        if (first_rx[o] < 0) first_rx[o] = cyc;
        last_rx[o] = cyc;
        check($sformatf("src_ok_o%0d", o), s < NS, 1'b1);
        if (s < NS) begin
            if (lock_src[o] < 0) hdr_log[o].push_back(s);
            else check($sformatf("atomic_o%0d", o), s, lock_src[o]);
            lock_src[o] = f[XLEN] ? -1 : s;
            check($sformatf("sb_nonempty_o%0d_s%0d", o, s), exp_q[o*NS + s].size() > 0, 1'b1);
            if (exp_q[o*NS + s].size() > 0)
                check($sformatf("sb_flit_o%0d_s%0d", o, s), f, exp_q[o*NS + s].pop_front());
        end
    endtask

    // One clock: drive at the falling edge, sample handshakes 1 ns before the rising edge.
    task automatic step(input bit r);
        logic [XLEN:0] f;
        logic          v, rd;
        @(negedge clk);
        cyc++;
        rst = r;
        if (r) model_clear();
        for (int s = 0; s < NS; s++)
            if (!r && !cur_v[s] && src_q[s].size() > 0 && $urandom_range(0, 99) >= gap_pct[s])
                cur_v[s] = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            f = cur_v[c] ? src_q[c][0] : '0;
            if (r) f = {1'b0, $urandom, $urandom};
            bus.ring_in_valid[c]            = r | cur_v[c];
            bus.ring_in_last[c]             = f[XLEN];
            bus.ring_in_data[c*XLEN +: XLEN] = f[XLEN-1:0];
            bus.ring_out_ready[c]           = ($urandom_range(0, 99) < rdy_pct[c]);
        end
        f = cur_v[CHANNELS] ? src_q[CHANNELS][0] : '0;
        if (r) f = {1'b1, $urandom, $urandom};
        bus.local_in_valid  = r | cur_v[CHANNELS];
        bus.local_in_last   = f[XLEN];
        bus.local_in_data   = f[XLEN-1:0];
        bus.local_out_ready = ($urandom_range(0, 99) < rdy_pct[CHANNELS]);
        #4;
        if (r) begin
            check("rst_ready", {bus.local_in_ready, bus.ring_in_ready}, '0);
            if (rst_prev) check("rst_out_valid", {bus.local_out_valid, bus.ring_out_valid}, '0);
        end else begin
            for (int s = 0; s < NS; s++) begin
                rd = (s < CHANNELS) ? bus.ring_in_ready[s] : bus.local_in_ready;
                if (cur_v[s] && rd) begin
                    if (first_tx[s] < 0) first_tx[s] = cyc;
                    tx_cnt[s]++;
                    void'(src_q[s].pop_front());
                    cur_v[s] = 1'b0;
                end else if (cur_v[s]) begin
                    stall_cnt[s]++;
                end
            end
            for (int o = 0; o < NO; o++) begin
                if (o < CHANNELS) begin
                    v  = bus.ring_out_valid[o] && bus.ring_out_ready[o];
                    f  = {bus.ring_out_last[o], bus.ring_out_data[o*XLEN +: XLEN]};
                end else begin
                    v  = bus.local_out_valid && bus.local_out_ready;
                    f  = {bus.local_out_last, bus.local_out_data};
                end
                if (v) monitor(o, f);
            end
        end
        rst_prev = r;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            step(1'b0);
            n++;
        end
        check({tag, "_drained"}, all_empty(), 1'b1);
    endtask

    task automatic set_rates(input int gap, input int rdy);
        for (int s = 0; s < NS; s++) gap_pct[s] = gap;
        for (int o = 0; o < NO; o++) rdy_pct[o] = rdy;
    endtask

    task automatic check_alternation(input string tag, input int o, input int n_hdr);
        check({tag, "_hdrs"}, hdr_log[o].size(), n_hdr);
        for (int i = 1; i < hdr_log[o].size(); i++)
            check($sformatf("%s_alt%0d", tag, i), hdr_log[o][i] != hdr_log[o][i-1], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        id  = {48'hABCD_0000_1234, NODE_ID};
        bus.ring_in_data = '0; bus.ring_in_last = '0; bus.ring_in_valid = '0;
        bus.ring_out_ready = '0; bus.local_in_data = '0; bus.local_in_last = 1'b0;
        bus.local_in_valid = 1'b0; bus.local_out_ready = 1'b0;
        set_rates(0, 100);
        clear_stats();

        // Reset with valids high, then the first header is taken right away.
        step(1'b1);
        step(1'b1);
        gen_packet(1, 1, 1'b0);
        step(1'b0);
        check("t1_first_hdr", first_tx[1], cyc);
        drain("t1", 20);

        // Local-bound and forward 3-flit packets on ring_in[1]: latency 1, one flit per cycle.
        clear_stats();
        gen_packet(1, 3, 1'b1);
        drain("t2a", 40);
        check("t2a_lo_cnt", rx_cnt[CHANNELS], 3);
        check("t2a_ro1_cnt", rx_cnt[1], 0);
        check("t2a_latency", first_rx[CHANNELS] - first_tx[1], 1);
        check("t2a_tput", last_rx[CHANNELS] - first_rx[CHANNELS], 2);
        clear_stats();
        gen_packet(1, 3, 1'b0);
        drain("t2b", 40);
        check("t2b_ro1_cnt", rx_cnt[1], 3);
        check("t2b_lo_cnt", rx_cnt[CHANNELS], 0);
        check("t2b_latency", first_rx[1] - first_tx[1], 1);
        check("t2b_tput", last_rx[1] - first_rx[1], 2);

        // Ring forward vs local injection contend for ring_out[INJECT_CH].
        clear_stats();
        for (int p = 0; p < 6; p++) begin
            gen_packet(INJECT_CH, 4, 1'b0);
            gen_packet(CHANNELS, 4, 1'b0);
        end
        drain("t3", 300);
        check("t3_flits", rx_cnt[INJECT_CH], 48);
        check_alternation("t3", INJECT_CH, 12);

        // Both channels local-bound under a random local_out ready pattern.
        clear_stats();
        rdy_pct[CHANNELS] = 60;
        for (int p = 0; p < 5; p++) begin
            gen_packet(0, 4, 1'b1);
            gen_packet(1, 4, 1'b1);
        end
        drain("t4", 600);
        check("t4_flits", rx_cnt[CHANNELS], 40);
        check_alternation("t4", CHANNELS, 10);

        // Back-to-back single-flit packets: ring_in[0] forward, ring_in[1] mixed.
        set_rates(0, 100);
        clear_stats();
        for (int p = 0; p < 20; p++) begin
            gen_packet(0, 1, 1'b0);
            gen_packet(1, 1, 1'($urandom_range(0, 1)));
        end
        drain("t5", 100);
        check("t5_stall0", stall_cnt[0], 0);
        check("t5_stall1", stall_cnt[1], 0);
        check("t5_total", rx_cnt[0] + rx_cnt[1] + rx_cnt[2], 40);

        // Reset during flit 2 of a local-bound packet, then a fresh forward header.
        clear_stats();
        gen_packet(1, 4, 1'b1);
        n = 0;
        while (tx_cnt[1] < 2 && n < 20) begin
            step(1'b0);
            n++;
        end
        check("t6_mid_packet", tx_cnt[1], 2);
        step(1'b1);
        step(1'b0);
        check("t6_out_valid", {bus.local_out_valid, bus.ring_out_valid}, '0);
        clear_stats();
        gen_packet(1, 2, 1'b0);
        gen_packet(1, 2, 1'b1);
        drain("t6", 40);
        check("t6_ro1_cnt", rx_cnt[1], 2);
        check("t6_lo_cnt", rx_cnt[CHANNELS], 2);

        // Random traffic with random gaps and output stalls.
        for (int round = 0; round < 4; round++) begin
            clear_stats();
            for (int s = 0; s < NS; s++) gap_pct[s] = $urandom_range(0, 50);
            for (int o = 0; o < NO; o++) rdy_pct[o] = $urandom_range(30, 100);
            for (int p = 0; p < 8; p++)
                for (int s = 0; s < NS; s++)
                    gen_packet(s, $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            drain($sformatf("rand%0d", round), 3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
